// File: rtl/xor_checksum_checker_if.sv
// Stream interface for the XOR checksum checker: input beat channel and
// per-frame result channel, each with its own valid/ready handshake.
interface xor_checksum_checker_if #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_checksum;
  logic              out_match;
  logic [LEN_W-1:0]  out_len;
  logic              out_len_err;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_checksum, out_match, out_len, out_len_err
  );

  // Checker side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_checksum, out_match, out_len, out_len_err
  );
endinterface

// File: rtl/xor_checksum_checker.sv
// Streaming frame checker: XORs every beat of a frame except the last, then
// compares the running XOR with the last (check) beat and reports one result
// per frame together with the saturated beat count and a length-error flag.
module xor_checksum_checker #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  xor_checksum_checker_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] RESULT = 1'b1;

  logic [0:0]        state_reg, state_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic              ovf_reg, ovf_next;
  logic [DATA_W-1:0] checksum_reg, checksum_next;
  logic              match_reg, match_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              len_err_reg, len_err_next;

  logic in_fire;
  logic out_fire;
  logic cnt_full;

  assign in_fire  = bus.in_valid && (state_reg == ACCUM);
  assign out_fire = bus.out_ready && (state_reg == RESULT);
  assign cnt_full = (cnt_reg == LEN_MAX);

  // Next-state: accumulate beats in ACCUM, latch the result on the check
  // beat, hold the result until the consumer takes it.
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    ovf_next      = ovf_reg;
    checksum_next = checksum_reg;
    match_next    = match_reg;
    len_next      = len_reg;
    len_err_next  = len_err_reg;

    if (state_reg == ACCUM) begin
      if (in_fire) begin
        if (!bus.in_last) begin
          acc_next = acc_reg ^ bus.in_data;
          // Counter saturates; once it has reached MAX_LEN any further
          // data beat means the frame is overlong.
          if (cnt_full) begin
            ovf_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          checksum_next = acc_reg;
          match_next    = (acc_reg == bus.in_data);
          len_next      = cnt_full ? LEN_MAX : cnt_reg + 1'b1;
          len_err_next  = ovf_reg | cnt_full;
          acc_next      = '0;
          cnt_next      = '0;
          ovf_next      = 1'b0;
          state_next    = RESULT;
        end
      end
    end else begin
      if (out_fire) begin
        state_next = ACCUM;
      end
    end
  end

  // State and result registers; reset discards any partial frame or result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ACCUM;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      checksum_reg <= '0;
      match_reg    <= 1'b0;
      len_reg      <= '0;
      len_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      ovf_reg      <= ovf_next;
      checksum_reg <= checksum_next;
      match_reg    <= match_next;
      len_reg      <= len_next;
      len_err_reg  <= len_err_next;
    end
  end

  assign bus.in_ready     = (state_reg == ACCUM);
  assign bus.out_valid    = (state_reg == RESULT);
  assign bus.out_checksum = checksum_reg;
  assign bus.out_match    = match_reg;
  assign bus.out_len      = len_reg;
  assign bus.out_len_err  = len_err_reg;
endmodule

// File: tb/tb_xor_checksum_checker.sv
// Directed bench for xor_checksum_checker: a frame-level model predicts each
// result, a per-cycle monitor compares the DUT against it, and each test
// also pins the expected result with hand-computed literals.
module tb_xor_checksum_checker;
  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 16;

  logic clk;
  logic rst_n;

  xor_checksum_checker_if #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) bus ();

  xor_checksum_checker #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cs;
    logic       match;
    int         len;
    logic       err;
  } res_t;

  res_t       exp_q[$];
  res_t       last_res;
  logic [7:0] frame_xor;
  int         frame_beats;
  int         tests;
  int         fails;
  int         seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: checksum is the XOR of every beat before the last, length
  // is the total beat count clipped to MAX_LEN, error when it exceeds MAX_LEN.
  task automatic model_beat(input logic [7:0] d, input logic last);
    res_t r;
    frame_beats++;
    if (!last) begin
      frame_xor ^= d;
    end else begin
      r.cs    = frame_xor;
      r.match = (frame_xor == d);
      r.len   = (frame_beats > MAX_LEN) ? MAX_LEN : frame_beats;
      r.err   = (frame_beats > MAX_LEN);
      exp_q.push_back(r);
      last_res    = r;
      frame_xor   = '0;
      frame_beats = 0;
    end
  endtask

  // Present one beat and hold it until accepted; returns 1ns after the
  // accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic last);
    bit accepted;
    accepted = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      check("send_timeout", 32'(0), 32'(1));
    end else begin
      model_beat(d, last);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Result must be visible on the first cycle after the check beat and,
  // with out_ready high, last exactly one cycle.
  task automatic expect_result(input logic [7:0] cs, input logic m, input int len, input logic err);
    @(negedge clk);
    check("latency_valid", 32'(bus.out_valid), 32'(1));
    check("lit_checksum", 32'(bus.out_checksum), 32'(cs));
    check("lit_match", 32'(bus.out_match), 32'(m));
    check("lit_len", 32'(bus.out_len), 32'(len));
    check("lit_len_err", 32'(bus.out_len_err), 32'(err));
    check("model_checksum", 32'(last_res.cs), 32'(cs));
    check("model_match", 32'(last_res.match), 32'(m));
    check("model_len", 32'(last_res.len), 32'(len));
    check("model_len_err", 32'(last_res.err), 32'(err));
    @(posedge clk);
    #1;
    check("one_cycle_valid", 32'(bus.out_valid), 32'(0));
    check("ready_returns", 32'(bus.in_ready), 32'(1));
  endtask

  // Per-cycle monitor against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", 32'(bus.in_ready), 32'(1));
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_checksum", 32'(bus.out_checksum), 32'(0));
      check("rst_match", 32'(bus.out_match), 32'(0));
      check("rst_len", 32'(bus.out_len), 32'(0));
      check("rst_len_err", 32'(bus.out_len_err), 32'(0));
    end else begin
      check("ready_vs_valid", 32'(bus.in_ready), 32'(!bus.out_valid));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(bus.out_valid), 32'(0));
        end else begin
          check("mon_checksum", 32'(bus.out_checksum), 32'(exp_q[0].cs));
          check("mon_match", 32'(bus.out_match), 32'(exp_q[0].match));
          check("mon_len", 32'(bus.out_len), 32'(exp_q[0].len));
          check("mon_len_err", 32'(bus.out_len_err), 32'(exp_q[0].err));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            seen++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests        = 0;
    fails        = 0;
    seen         = 0;
    frame_xor    = '0;
    frame_beats  = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Matching frame
    send_beat(8'h12, 1'b0);
    send_beat(8'h34, 1'b0);
    send_beat(8'h26, 1'b1);
    expect_result(8'h26, 1'b1, 3, 1'b0);
    $display("[TB] frame match: 12 34 | 26");

    // Mismatch with 5 cycles of backpressure
    bus.out_ready = 1'b0;
    send_beat(8'hFF, 1'b0);
    send_beat(8'h0F, 1'b0);
    send_beat(8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'(1));
      check("bp_in_ready", 32'(bus.in_ready), 32'(0));
      check("bp_checksum", 32'(bus.out_checksum), 32'(8'hF0));
      check("bp_match", 32'(bus.out_match), 32'(0));
      check("bp_len", 32'(bus.out_len), 32'(3));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_still_valid", 32'(bus.out_valid), 32'(1));
    @(posedge clk);
    #1;
    check("bp_released", 32'(bus.out_valid), 32'(0));
    $display("[TB] frame mismatch+backpressure: FF 0F | 00");

    // Single-beat frames
    send_beat(8'h00, 1'b1);
    expect_result(8'h00, 1'b1, 1, 1'b0);
    $display("[TB] frame single: | 00");
    send_beat(8'h5A, 1'b1);
    expect_result(8'h00, 1'b0, 1, 1'b0);
    $display("[TB] frame single: | 5A");

    // Overlong frame, then a legal one
    for (int i = 0; i < 16; i++) send_beat(8'h01, 1'b0);
    send_beat(8'h00, 1'b1);
    expect_result(8'h00, 1'b1, 16, 1'b1);
    $display("[TB] frame overlong: 16x01 | 00");
    send_beat(8'h3C, 1'b0);
    send_beat(8'h3C, 1'b1);
    expect_result(8'h3C, 1'b1, 2, 1'b0);
    $display("[TB] frame after overlong: 3C | 3C");

    // Input gaps
    send_beat(8'h0A, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send_beat(8'h0B, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send_beat(8'h01, 1'b1);
    expect_result(8'h01, 1'b1, 3, 1'b0);
    $display("[TB] frame gaps: 0A 0B | 01");

    // Reset mid-frame discards the partial frame
    send_beat(8'h77, 1'b0);
    send_beat(8'h88, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    frame_xor   = '0;
    frame_beats = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(8'hA5, 1'b0);
    send_beat(8'hA5, 1'b1);
    expect_result(8'hA5, 1'b1, 2, 1'b0);
    $display("[TB] frame after reset: A5 | A5");

    repeat (3) @(posedge clk);
    #1;
    check("results_seen", 32'(seen), 32'(8));
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
